// File: rtl/rng_sched.sv
// Round-robin scheduler sharing one external Fibonacci LFSR among N_REQ requesters.
// Each grant carries a value in [0, limit) chosen by rejection sampling, with a bounded fallback.
module rng_sched #(
    parameter int N_REQ     = 4,
    parameter int RW        = 7,
    parameter int LW        = 13,
    parameter int MAX_TRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*RW-1:0]   limit,
    input  logic                  seed_wr,
    input  logic [LW-1:0]         seed_in,
    input  logic [LW-1:0]         lfsr_val,
    output logic                  lfsr_step,
    output logic                  lfsr_load,
    output logic [LW-1:0]         lfsr_seed,
    output logic [N_REQ-1:0]      gnt,
    output logic                  rnd_valid,
    output logic [RW-1:0]         rnd_out,
    output logic                  rnd_fb,
    output logic                  busy
);

    // Handshake: req is a level held until its 1-cycle gnt; rnd_valid pulses with gnt,
    // and rnd_out/rnd_fb stay stable until the next grant.

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_GRANT = 3'd4;
    localparam logic [2:0] S_SEED  = 3'd5;

    localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);
    localparam logic [TW-1:0]    LAST_TRY  = TW'(MAX_TRIES - 1);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_REQ - 1);

    logic [2:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;
    logic [RW-1:0] lim;
    logic [TW-1:0] tries;
    logic          pend;
    logic [LW-1:0] pend_seed;

    logic          arb_hit;
    logic [IW-1:0] arb_idx;
    logic [RW-1:0] arb_lim;
    logic [RW-1:0] sample;
    logic          accept;
    logic          lfsr_hi_unused;
    int            j;

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!arb_hit && req[j]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(j);
            end
        end
    end

    assign arb_lim        = limit[int'(arb_idx)*RW +: RW];
    assign sample         = lfsr_val[RW-1:0];
    assign accept         = (lim == '0) || (sample < lim);
    assign lfsr_hi_unused = ^lfsr_val[LW-1:RW];
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SEED;
            rr_ptr    <= '0;
            idx       <= '0;
            lim       <= '0;
            tries     <= '0;
            pend      <= 1'b0;
            pend_seed <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
            rnd_fb    <= 1'b0;
            lfsr_step <= 1'b0;
            lfsr_load <= 1'b1;
            lfsr_seed <= '1;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            lfsr_step <= 1'b0;
            lfsr_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        state     <= S_SEED;
                        pend      <= 1'b0;
                        lfsr_load <= 1'b1;
                        // An all-zero seed would lock the LFSR, so it becomes all-ones.
                        lfsr_seed <= (pend_seed == '0) ? '1 : pend_seed;
                    end else if (|req) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (arb_hit) begin
                        idx       <= arb_idx;
                        lim       <= arb_lim;
                        tries     <= '0;
                        lfsr_step <= 1'b1;
                        state     <= S_STEP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: state <= S_CHECK;
                S_CHECK: begin
                    if (accept || tries == LAST_TRY) begin
                        rnd_out   <= accept ? sample : lim - RW'(1);
                        rnd_fb    <= !accept;
                        gnt       <= GNT_ONE << idx;
                        rnd_valid <= 1'b1;
                        state     <= S_GRANT;
                    end else begin
                        tries     <= tries + TW'(1);
                        lfsr_step <= 1'b1;
                        state     <= S_STEP;
                    end
                end
                S_GRANT: begin
                    rr_ptr <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
                    state  <= S_IDLE;
                end
                S_SEED:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // A new seed write wins over the clear done when a pending seed is applied.
            if (seed_wr) begin
                pend      <= 1'b1;
                pend_seed <= seed_in;
            end
        end
    end

endmodule

// File: tb/tb_rng_sched.sv
// Bench for rng_sched: external LFSR model, transaction-level predictor for round-robin
// order, rejection-sampled values, fallback, step counts, latency and seeding.
module tb_rng_sched;

    localparam int N  = 4;
    localparam int RW = 7;
    localparam int LW = 13;
    localparam int MT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [N*RW-1:0] limit = '0;
    logic            seed_wr = 1'b0;
    logic [LW-1:0]   seed_in = '0;
    logic [LW-1:0]   lfsr_q;
    logic            lfsr_step, lfsr_load, rnd_valid, rnd_fb, busy;
    logic [LW-1:0]   lfsr_seed;
    logic [N-1:0]    gnt;
    logic [RW-1:0]   rnd_out;

    logic [N-1:0]    req_4 = '0;
    logic [N*RW-1:0] limit_4 = '0;
    logic            seed_wr_4 = 1'b0;
    logic [LW-1:0]   lfsr_q4;
    logic            lfsr_step_4, lfsr_load_4, rnd_valid_4, rnd_fb_4, busy_4;
    logic [LW-1:0]   lfsr_seed_4;
    logic [N-1:0]    gnt_4;
    logic [RW-1:0]   rnd_out_4;

    rng_sched #(.N_REQ(N), .RW(RW), .LW(LW), .MAX_TRIES(MT)) u_dut (
        .clk(clk), .rst(rst), .req(req), .limit(limit), .seed_wr(seed_wr),
        .seed_in(seed_in), .lfsr_val(lfsr_q), .lfsr_step(lfsr_step),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .gnt(gnt),
        .rnd_valid(rnd_valid), .rnd_out(rnd_out), .rnd_fb(rnd_fb), .busy(busy)
    );

    rng_sched #(.N_REQ(N), .RW(RW), .LW(LW), .MAX_TRIES(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req_4), .limit(limit_4), .seed_wr(seed_wr_4),
        .seed_in(seed_in), .lfsr_val(lfsr_q4), .lfsr_step(lfsr_step_4),
        .lfsr_load(lfsr_load_4), .lfsr_seed(lfsr_seed_4), .gnt(gnt_4),
        .rnd_valid(rnd_valid_4), .rnd_out(rnd_out_4), .rnd_fb(rnd_fb_4), .busy(busy_4)
    );

    int checks = 0;
    int failures = 0;
    int step_cnt = 0, load_cnt = 0, overlap = 0, step_cnt4 = 0;
    int rr_m = 0;
    logic [LW-1:0] exp_seed = '1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] q);
        return {q[LW-2:0], q[12] ^ q[5]};
    endfunction

    // Walk the LFSR from a snapshot, accepting the first sample below the bound.
    function automatic void predict(input logic [LW-1:0] s0, input int lim, input int max_t,
                                    output int v, output int fb, output int tries);
        logic [LW-1:0] s = s0;
        for (int t = 1; t <= max_t; t++) begin
            s = lfsr_next(s);
            v = int'(s[RW-1:0]);
            if (lim == 0 || v < lim) begin
                fb = 0;
                tries = t;
                return;
            end
        end
        v = lim - 1;
        fb = 1;
        tries = max_t;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int k = 0; k < N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (lfsr_load) lfsr_q <= lfsr_seed;
        else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
        if (lfsr_load_4) lfsr_q4 <= lfsr_seed_4;
        else if (lfsr_step_4) lfsr_q4 <= lfsr_next(lfsr_q4);
        if (lfsr_step) step_cnt <= step_cnt + 1;
        if (lfsr_step_4) step_cnt4 <= step_cnt4 + 1;
        if (lfsr_load) load_cnt <= load_cnt + 1;
        if (lfsr_step && lfsr_load) overlap <= overlap + 1;
    end

    always @(negedge clk)
        if (!rst && lfsr_load) check_eq("load_seed", 32'(lfsr_seed), 32'(exp_seed));

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        req_4 = '0;
        exp_seed = '1;
        repeat (2) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_valid", 32'(rnd_valid), 0);
        check_eq("rst_rnd", 32'(rnd_out), 0);
        check_eq("rst_fb", 32'(rnd_fb), 0);
        check_eq("rst_step", 32'(lfsr_step), 0);
        rst = 1'b0;
        check_eq("post_rst_load", 32'(lfsr_load), 1);
        check_eq("post_rst_seed", 32'(lfsr_seed), 32'h1FFF);
        rr_m = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic run_txn(input logic [N-1:0] r, input logic [N*RW-1:0] lims,
                           input int seed_at, input logic [LW-1:0] sv, output logic [N-1:0] g);
        int idx, n, ev, efb, et, sb;
        logic snapped;
        logic [LW-1:0] snap;
        wait_idle();
        idx = pick(r, rr_m);
        limit = lims;
        req = r;
        snap = lfsr_q;
        snapped = 1'b0;
        sb = step_cnt;
        n = 0;
        g = '0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            seed_wr = (n == seed_at);
            if (seed_wr) begin
                seed_in = sv;
                exp_seed = (sv == '0) ? '1 : sv;
            end
            if (lfsr_step && !snapped) begin
                snap = lfsr_q;
                snapped = 1'b1;
            end
            if (gnt != '0) break;
        end
        seed_wr = 1'b0;
        g = gnt;
        if (gnt == '0) begin
            check_eq("gnt_timeout", 0, 1);
            req = '0;
            return;
        end
        predict(snap, int'(lims[idx*RW +: RW]), MT, ev, efb, et);
        check_eq("gnt_idx", 32'(gnt), 32'(1 << idx));
        check_eq("rnd_valid", 32'(rnd_valid), 1);
        check_eq("rnd_out", 32'(rnd_out), 32'(ev));
        check_eq("rnd_fb", 32'(rnd_fb), 32'(efb));
        check_eq("step_count", 32'(step_cnt - sb), 32'(et));
        check_eq("latency", 32'(n), 32'(2 + 2 * et));
        rr_m = (idx + 1) % N;
        req = '0;
        @(negedge clk);
        check_eq("gnt_pulse", 32'(gnt), 0);
        check_eq("valid_pulse", 32'(rnd_valid), 0);
        check_eq("rnd_hold", 32'(rnd_out), 32'(ev));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g;
        logic [N*RW-1:0] lims;
        int s0, lc, n, seen;

        do_reset();

        // Four-try instance: 126,124,120,112 all reject against 100, so fallback 99.
        req_4 = 4'b0001;
        limit_4 = '0;
        limit_4[RW-1:0] = 7'd100;
        s0 = step_cnt4;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_4 == '0 && n < 30);
        check_eq("t4_gnt", 32'(gnt_4), 1);
        check_eq("t4_rnd", 32'(rnd_out_4), 99);
        check_eq("t4_fb", 32'(rnd_fb_4), 1);
        check_eq("t4_steps", 32'(step_cnt4 - s0), 4);
        req_4 = '0;

        run_txn(4'b0001, '0, 0, '0, g);
        check_eq("t1_rnd", 32'(rnd_out), 126);

        do_reset();
        lims = '0;
        lims[RW-1:0] = 7'd100;
        s0 = step_cnt;
        run_txn(4'b0001, lims, 0, '0, g);
        check_eq("t2_rnd", 32'(rnd_out), 96);
        check_eq("t2_steps", 32'(step_cnt - s0), 5);

        do_reset();
        run_txn(4'b1010, '0, 0, '0, g);
        check_eq("rr_order0", 32'(g), 32'b0010);
        run_txn(4'b1010, '0, 0, '0, g);
        check_eq("rr_order1", 32'(g), 32'b1000);
        run_txn(4'b1010, '0, 0, '0, g);
        check_eq("rr_order2", 32'(g), 32'b0010);
        run_txn(4'b1010, '0, 0, '0, g);
        check_eq("rr_order3", 32'(g), 32'b1000);

        // Zero seed written during CHECK must reload all-ones before the next service.
        lc = load_cnt;
        run_txn(4'b0001, '0, 3, '0, g);
        run_txn(4'b0001, '0, 0, '0, g);
        check_eq("seed0_loads", 32'(load_cnt - lc), 1);
        check_eq("seed0_rnd", 32'(rnd_out), 126);

        // Reset while in STEP aborts the request.
        wait_idle();
        req = 4'b0001;
        limit = '0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_step", 32'(lfsr_step), 1);
        exp_seed = '1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_gnt", 32'(gnt), 0);
        check_eq("mid_rst_valid", 32'(rnd_valid), 0);
        check_eq("mid_rst_step", 32'(lfsr_step), 0);
        check_eq("mid_rst_rnd", 32'(rnd_out), 0);
        check_eq("mid_rst_load", 32'(lfsr_load), 1);
        rst = 1'b0;
        req = '0;
        rr_m = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt != '0) seen++;
        end
        check_eq("mid_rst_no_gnt", 32'(seen), 0);
        check_eq("mid_rst_reload", 32'(lfsr_q), 32'h1FFF);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            logic [LW-1:0] sv;
            int sa;
            r = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: lims[i*RW +: RW] = '0;
                    1: lims[i*RW +: RW] = RW'($urandom_range(1, 8));
                    default: lims[i*RW +: RW] = RW'($urandom_range(1, 127));
                endcase
            end
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            sv = ($urandom_range(0, 2) == 0) ? '0 : LW'($urandom_range(0, 8191));
            run_txn(r, lims, sa, sv, g);
        end

        wait_idle();
        check_eq("step_load_overlap", 32'(overlap), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
